// File: rtl/spm_stream_agent.sv
// Scratchpad stream agent: runs a small program of strided read/write
// bursts on one scratchpad port and buffers read returns in a FIFO.
module spm_stream_agent #(
  parameter int A_W        = 8,
  parameter int D_W        = 32,
  parameter int DESC_DEPTH = 8,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [23:0]      desc_i,
  input  logic             run,
  input  logic [D_W-1:0]   wr_data_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  output logic [D_W-1:0]   rd_data_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [D_W+A_W+1:0] req_o,
  input  logic [D_W-1:0]   rsp_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam int LW = $clog2(DESC_DEPTH + 1);
  localparam int BW = $clog2(DESC_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, DRAIN, DONE
  } state_t;

  state_t state, state_nx;

  logic [23:0]    dbuf [DESC_DEPTH];
  logic [LW-1:0]  load_cnt, load_at;
  logic [LW-1:0]  idx, idx_inc;
  logic           init_q;

  logic           dir;
  logic [A_W-1:0] addr;
  logic [7:0]     stride;
  logic [7:0]     remaining;
  logic           issue, last, can_read;

  logic [CW-1:0]  outstanding, fifo_cnt;
  logic [CW:0]    in_use;
  logic [PW:0]    wptr, rptr;
  logic [D_W-1:0] mem [FIFO_DEPTH];
  logic [RD_LAT-1:0] vld_sr;
  logic           push, pop, full, empty;

  // A new init burst restarts the program from entry 0.
  assign load_at  = init_q ? load_cnt : '0;
  assign idx_inc  = idx + LW'(1);
  assign last     = (remaining == 8'd1);

  assign fifo_cnt = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign full     = (fifo_cnt == CW'(FIFO_DEPTH));
  assign push     = vld_sr[RD_LAT-1];
  assign pop      = rd_valid_o & rd_ready_i;
  assign in_use   = {1'b0, outstanding} + {1'b0, fifo_cnt};
  assign can_read = in_use < (CW+1)'(FIFO_DEPTH);

  assign rd_valid_o = !empty;
  assign rd_data_o  = empty ? '0 : mem[rptr[PW-1:0]];
  assign busy_o     = (state != IDLE);
  assign done_o     = (state == DONE);

  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    wr_ready_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (run)
          state_nx = (load_cnt != '0) ? FETCH : DONE;
      end
      FETCH: state_nx = ISSUE;
      ISSUE: begin
        wr_ready_o = dir;
        issue      = dir ? wr_valid_i : can_read;
        if (issue && last)
          state_nx = (idx_inc < load_cnt) ? FETCH : DRAIN;
      end
      DRAIN: begin
        if (outstanding == '0 && empty)
          state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      load_cnt  <= '0;
      init_q    <= 1'b0;
      idx       <= '0;
      dir       <= 1'b0;
      addr      <= '0;
      stride    <= '0;
      remaining <= '0;
      req_o     <= '0;
    end else begin
      state  <= state_nx;
      init_q <= init && (state == IDLE);
      if (state == IDLE && init)
        load_cnt <= (load_at == LW'(DESC_DEPTH)) ? load_at : load_at + LW'(1);
      if (state == FETCH) begin
        dir       <= dbuf[idx[BW-1:0]][23];
        addr      <= dbuf[idx[BW-1:0]][22:15];
        remaining <= {1'b0, dbuf[idx[BW-1:0]][14:8]} + 8'd1;
        stride    <= dbuf[idx[BW-1:0]][7:0];
      end
      if (issue) begin
        addr      <= addr + stride;
        remaining <= remaining - 8'd1;
        if (last)
          idx <= idx_inc;
      end
      if (state == DONE)
        idx <= '0;
      req_o <= '0;
      if (issue)
        req_o <= dir ? {1'b1, wr_data_i, 1'b0, addr}
                     : {1'b0, {D_W{1'b0}}, 1'b1, addr};
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && init && load_at < LW'(DESC_DEPTH))
      dbuf[load_at[BW-1:0]] <= desc_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      wptr        <= '0;
      rptr        <= '0;
      vld_sr      <= '0;
    end else begin
      vld_sr[0] <= req_o[A_W];
      for (int i = 1; i < RD_LAT; i++)
        vld_sr[i] <= vld_sr[i-1];
      if ((issue && !dir) && !push)
        outstanding <= outstanding + CW'(1);
      else if (!(issue && !dir) && push)
        outstanding <= outstanding - CW'(1);
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr[PW-1:0]] <= rsp_i;
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst) !(push && full && !pop)
  );

endmodule
